// File: rtl/pico_pkg.sv
// Shared pico_mips definitions: opcodes, fetch states, default widths and field positions.
package pico_pkg;

  localparam int unsigned PC_WIDTH_DEF = 8;
  localparam int unsigned IW_DEF       = 10;
  localparam int unsigned IMM_LSB      = 0;
  localparam int unsigned IMM_MSB      = 7;
  localparam int unsigned IMM_W        = IMM_MSB - IMM_LSB + 1;
  localparam int unsigned OPC_W        = 2;

  typedef enum logic [OPC_W-1:0] {
    ADD  = 2'd0,
    IMM  = 2'd1,
    MULT = 2'd2,
    BRAN = 2'd3
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control and memory data in, fetch address and decoded fields out.
interface fetch_unit_if
  import pico_pkg::*;
#(
  parameter int unsigned PC_WIDTH = PC_WIDTH_DEF,
  parameter int unsigned IW       = IW_DEF
);
  logic                run;
  logic                stall;
  logic                bran;
  logic                cond;
  logic [IW-1:0]       instr_in;
  logic [PC_WIDTH-1:0] pc;
  logic [OPC_W-1:0]    opcode;
  logic [IMM_W-1:0]    imm;
  logic                valid;
  logic                halted;

  // Driver side: decoder/control and program memory
  modport master (
    output run, stall, bran, cond, instr_in,
    input  pc, opcode, imm, valid, halted
  );

  // Fetch stage side
  modport slave (
    input  run, stall, bran, cond, instr_in,
    output pc, opcode, imm, valid, halted
  );
endinterface

// File: rtl/pc_adder.sv
// Next-pc generation: sequential pc+1 or branch target pc_ir + sign-extended imm.
module pc_adder
  import pico_pkg::*;
#(
  parameter int unsigned PC_WIDTH = PC_WIDTH_DEF
) (
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic [PC_WIDTH-1:0] pc_ir_i,
  input  logic [IMM_W-1:0]    imm_i,
  input  logic                sel_branch_i,
  output logic [PC_WIDTH-1:0] next_pc_c_o
);

  logic [PC_WIDTH-1:0] imm_ext_c;

  // Sign-extend the immediate to the pc width; sums wrap modulo 2^PC_WIDTH
  always_comb begin
    imm_ext_c   = PC_WIDTH'(signed'(imm_i));
    next_pc_c_o = sel_branch_i ? (pc_ir_i + imm_ext_c) : (pc_i + PC_WIDTH'(1));
  end

endmodule

// File: rtl/fetch_unit.sv
// pico_mips instruction fetch stage: pc, IR, one-slot branch flush, stall hold.
// Optional build macro HALT_DETECT_EN: a taken branch-to-self (imm=0) enters HALT.
module fetch_unit
  import pico_pkg::*;
#(
  parameter int unsigned PC_WIDTH = PC_WIDTH_DEF,
  parameter int unsigned IW       = IW_DEF
) (
  input logic         clk,
  input logic         n_reset,
  fetch_unit_if.slave f
);

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_ir_q, pc_ir_d;
  logic [IW-1:0]       ir_q, ir_d;
  logic                valid_q, valid_d;
  logic                taken_c;
  logic                halt_req_c;
  logic [PC_WIDTH-1:0] next_pc_c;
  logic [IMM_W-1:0]    ir_imm_c;

  assign ir_imm_c = ir_q[IMM_MSB:IMM_LSB];

  // A branch only counts for a live IR slot
  assign taken_c = valid_q & f.bran & f.cond;

`ifdef HALT_DETECT_EN
  assign halt_req_c = taken_c & (ir_imm_c == IMM_W'(0));
`else
  assign halt_req_c = 1'b0;
`endif

  pc_adder #(.PC_WIDTH(PC_WIDTH)) u_pc_adder (
    .pc_i         (pc_q),
    .pc_ir_i      (pc_ir_q),
    .imm_i        (ir_imm_c),
    .sel_branch_i (taken_c),
    .next_pc_c_o  (next_pc_c)
  );

  // Fetch FSM state register and datapath registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      pc_ir_q <= '0;
      ir_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc_ir_q <= pc_ir_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
    end
  end

  // Next-state and datapath update; stall overrides branch and run
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc_ir_d = pc_ir_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (f.run) state_d = RUN;
      end
      RUN: begin
        if (!f.stall) begin
          if (halt_req_c) begin
            valid_d = 1'b0;
            state_d = HALT;
          end else if (taken_c) begin
            // Redirect and flush the wrong-path word
            pc_d    = next_pc_c;
            valid_d = 1'b0;
            if (!f.run) state_d = IDLE;
          end else if (!f.run) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end else begin
            ir_d    = f.instr_in;
            pc_ir_d = pc_q;
            pc_d    = next_pc_c;
            valid_d = 1'b1;
          end
        end
      end
      HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

`ifdef HALT_DETECT_EN
  logic halted_q;

  // Halt indication, registered alongside the state change
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) halted_q <= 1'b0;
    else          halted_q <= (state_d == HALT);
  end

  assign f.halted = halted_q;
`else
  assign f.halted = 1'b0;
`endif

  assign f.pc     = pc_q;
  assign f.valid  = valid_q;
  assign f.opcode = ir_q[IW-1:IW-OPC_W];
  assign f.imm    = ir_imm_c;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; expected values are hand-derived from the program image.
module tb_fetch_unit;
  import pico_pkg::*;

  logic clk;
  logic n_reset;
  logic [9:0] mem [256];
  int unsigned n_checks;
  int unsigned n_fail;

  fetch_unit_if #(.PC_WIDTH(8), .IW(10)) bus ();

  fetch_unit #(.PC_WIDTH(8), .IW(10)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .f       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational program memory
  always_comb bus.instr_in = mem[bus.pc];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0]   = 10'h012;
    mem[1]   = 10'h105;
    mem[2]   = 10'h203;
    mem[3]   = 10'h0FF;
    mem[4]   = 10'h0AA;
    mem[5]   = 10'h3FD;
    mem[6]   = 10'h3F8;
    mem[7]   = 10'h300;
    mem[254] = 10'h1AB;
    mem[255] = 10'h1CD;

    n_reset = 1'b0; bus.run = 1'b0; bus.stall = 1'b0; bus.bran = 1'b0; bus.cond = 1'b0;
    #3;
    chk("rst_pc", 32'(bus.pc), 32'h0);
    chk("rst_valid", 32'(bus.valid), 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);
    chk("rst_opcode", 32'(bus.opcode), 32'h0);
    chk("rst_imm", 32'(bus.imm), 32'h0);

    @(negedge clk);
    n_reset = 1'b1;
    bus.run = 1'b1;
    tick(); chk("idle2run_pc", 32'(bus.pc), 32'h0); chk("idle2run_valid", 32'(bus.valid), 32'h0);
    tick(); chk("f0_pc", 32'(bus.pc), 32'h1); chk("f0_valid", 32'(bus.valid), 32'h1);
            chk("f0_opc", 32'(bus.opcode), 32'(ADD)); chk("f0_imm", 32'(bus.imm), 32'h12);
    tick(); chk("f1_pc", 32'(bus.pc), 32'h2); chk("f1_opc", 32'(bus.opcode), 32'(IMM)); chk("f1_imm", 32'(bus.imm), 32'h05);
    tick(); chk("f2_pc", 32'(bus.pc), 32'h3); chk("f2_opc", 32'(bus.opcode), 32'(MULT));
    tick(); chk("f3_pc", 32'(bus.pc), 32'h4); chk("f3_opc", 32'(bus.opcode), 32'(ADD)); chk("f3_imm", 32'(bus.imm), 32'hFF);

    // Pause at pc=4: IR still shown this cycle, then idle
    bus.run = 1'b0;
    #1; chk("pause_last_valid", 32'(bus.valid), 32'h1);
    tick(); chk("pause_valid", 32'(bus.valid), 32'h0); chk("pause_pc", 32'(bus.pc), 32'h4);
    tick(); chk("pause2_valid", 32'(bus.valid), 32'h0); chk("pause2_pc", 32'(bus.pc), 32'h4);
    bus.run = 1'b1;
    tick(); chk("resume_pc", 32'(bus.pc), 32'h4); chk("resume_valid", 32'(bus.valid), 32'h0);
    tick(); chk("refetch4_pc", 32'(bus.pc), 32'h5); chk("refetch4_valid", 32'(bus.valid), 32'h1);
            chk("refetch4_imm", 32'(bus.imm), 32'hAA);
    tick(); chk("f5_pc", 32'(bus.pc), 32'h6); chk("f5_opc", 32'(bus.opcode), 32'(BRAN));

    // Taken branch at pc_ir=5, imm=-3 -> 2
    bus.bran = 1'b1; bus.cond = 1'b1;
    tick(); chk("br_pc", 32'(bus.pc), 32'h2); chk("br_flush", 32'(bus.valid), 32'h0);
    bus.bran = 1'b0; bus.cond = 1'b0;
    tick(); chk("tgt_pc", 32'(bus.pc), 32'h3); chk("tgt_valid", 32'(bus.valid), 32'h1);
            chk("tgt_opc", 32'(bus.opcode), 32'(MULT));

    // Stall with MULT in IR while bran/run toggle
    bus.stall = 1'b1; bus.cond = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.bran = (i != 1);
      bus.run  = (i == 1);
      tick();
      chk("stall_pc", 32'(bus.pc), 32'h3);
      chk("stall_opc", 32'(bus.opcode), 32'(MULT));
      chk("stall_valid", 32'(bus.valid), 32'h1);
    end
    // Stall drops: branch (pc_ir=2, imm=3 -> 5) and pause both take effect
    bus.stall = 1'b0; bus.bran = 1'b1; bus.run = 1'b0;
    tick(); chk("unstall_br_pc", 32'(bus.pc), 32'h5); chk("unstall_valid", 32'(bus.valid), 32'h0);
    bus.bran = 1'b0; bus.cond = 1'b0;
    tick(); chk("unstall_idle_pc", 32'(bus.pc), 32'h5); chk("unstall_idle_valid", 32'(bus.valid), 32'h0);
    bus.run = 1'b1;
    tick(); chk("run2_pc", 32'(bus.pc), 32'h5);
    tick(); chk("run2_f5_pc", 32'(bus.pc), 32'h6); chk("run2_f5_valid", 32'(bus.valid), 32'h1);

    // bran with cond=0 is not taken
    bus.bran = 1'b1; bus.cond = 1'b0;
    tick(); chk("nt_pc", 32'(bus.pc), 32'h7); chk("nt_imm", 32'(bus.imm), 32'hF8);
    // Taken from pc_ir=6, imm=-8 -> 0xFE
    bus.cond = 1'b1;
    tick(); chk("br_fe_pc", 32'(bus.pc), 32'hFE); chk("br_fe_valid", 32'(bus.valid), 32'h0);
    // Flushed slot ignores bran
    tick(); chk("flush_nobr_pc", 32'(bus.pc), 32'hFF); chk("flush_nobr_imm", 32'(bus.imm), 32'hAB);
            chk("flush_nobr_valid", 32'(bus.valid), 32'h1);
    bus.bran = 1'b0; bus.cond = 1'b0;
    tick(); chk("wrap_pc", 32'(bus.pc), 32'h00); chk("wrap_imm", 32'(bus.imm), 32'hCD);
    tick(); chk("post_wrap_pc", 32'(bus.pc), 32'h01); chk("post_wrap_imm", 32'(bus.imm), 32'h12);

    // Async reset mid-run
    n_reset = 1'b0; bus.run = 1'b0;
    #1; chk("async_rst_pc", 32'(bus.pc), 32'h0); chk("async_rst_valid", 32'(bus.valid), 32'h0);
    @(negedge clk);
    n_reset = 1'b1;
    tick(); chk("idle_hold_pc", 32'(bus.pc), 32'h0);
    bus.run = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) tick();
    chk("at7_pc", 32'(bus.pc), 32'h8); chk("at7_opc", 32'(bus.opcode), 32'(BRAN)); chk("at7_imm", 32'(bus.imm), 32'h0);

    // Branch-to-self at pc_ir=7
    bus.bran = 1'b1; bus.cond = 1'b1;
    tick();
`ifdef HALT_DETECT_EN
    chk("halt_halted", 32'(bus.halted), 32'h1); chk("halt_pc", 32'(bus.pc), 32'h8); chk("halt_valid", 32'(bus.valid), 32'h0);
    tick();
    chk("halt2_halted", 32'(bus.halted), 32'h1); chk("halt2_pc", 32'(bus.pc), 32'h8); chk("halt2_valid", 32'(bus.valid), 32'h0);
    n_reset = 1'b0;
    #1; chk("halt_rst_pc", 32'(bus.pc), 32'h0); chk("halt_rst_halted", 32'(bus.halted), 32'h0);
`else
    chk("self_pc", 32'(bus.pc), 32'h7); chk("self_valid", 32'(bus.valid), 32'h0); chk("self_halted", 32'(bus.halted), 32'h0);
    tick(); chk("self_refetch_pc", 32'(bus.pc), 32'h8); chk("self_refetch_valid", 32'(bus.valid), 32'h1);
    tick(); chk("self_loop_pc", 32'(bus.pc), 32'h7); chk("self_loop_halted", 32'(bus.halted), 32'h0);
    n_reset = 1'b0;
    #1; chk("self_rst_pc", 32'(bus.pc), 32'h0);
`endif
    bus.bran = 1'b0; bus.cond = 1'b0; bus.run = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    tick(); chk("final_idle_pc", 32'(bus.pc), 32'h0); chk("final_idle_valid", 32'(bus.valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
